bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 73 +++++++
 tb/tb_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter with bounded bursts in front of a synchronous single-port memory.
// Grants are combinational; read responses return one cycle later through a registered pending flag.
module bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam logic [3:0] MB = 4'(MAX_BURST);
  logic       owner;
  logic [3:0] burst_cnt;
  logic       pend;
  logic       pend_id;
  logic       any;
  logic       sel;
  logic       gnt;
  always_comb begin
    any = m0_req | m1_req;
    sel = (m0_req & m1_req) ? ((burst_cnt < MB) ? owner : ~owner) : m1_req;
    gnt = clrn & any;
    m0_gnt = gnt & ~sel;
    m1_gnt = gnt & sel;
    mem_en = gnt;
    mem_we = gnt & (sel ? m1_we : m0_we);
    mem_addr = gnt ? (sel ? m1_addr : m0_addr) : '0;
    mem_wdata = gnt ? (sel ? m1_wdata : m0_wdata) : '0;
  end
  // pend is cleared asynchronously so a read caught by reset never answers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      owner <= 1'b0;
      burst_cnt <= '0;
      pend <= 1'b0;
      pend_id <= 1'b0;
    end else begin
      pend <= gnt & ~mem_we;
      pend_id <= sel;
      if (!any)
        burst_cnt <= '0;
      else if (sel == owner)
        burst_cnt <= (burst_cnt == 4'hf) ? 4'hf : burst_cnt + 4'd1;
      else begin
        owner <= sel;
        burst_cnt <= 4'd1;
      end
    end
  end
  assign m0_rvalid = pend & ~pend_id;
  assign m1_rvalid = pend & pend_id;
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scenario tasks plus randomized traffic against a behavioural arbiter/memory model.
module tb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we;
  logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  int checks = 0;
  int errors = 0;
  int own = 0;
  int cnt = 0;
  bit pend = 0;
  int pend_id = 0;
  logic [DW-1:0] pend_data = '0;
  logic obs_g0, obs_g1;

  bus_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .clrn(clrn),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 16) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0101;
  endfunction

  // synchronous memory seen by the DUT
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
        else mem_rdata <= mem[mem_addr[7:0]];
      end
    end
  end

  task automatic tick(input string tag);
    bit any;
    int sel;
    logic ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [1:0] eg, ev;
    @(negedge clk);
    #1;
    any = m0_req | m1_req;
    sel = !any ? 0 : (m0_req && m1_req) ? (cnt < MB ? own : 1 - own) : (m1_req ? 1 : 0);
    ew = any && (sel ? m1_we : m0_we);
    ea = !any ? '0 : (sel ? m1_addr : m0_addr);
    ed = !any ? '0 : (sel ? m1_wdata : m0_wdata);
    eg = !any ? 2'b00 : (sel ? 2'b01 : 2'b10);
    ev = !pend ? 2'b00 : (pend_id ? 2'b01 : 2'b10);
    checks++;
    if ({m0_gnt, m1_gnt} !== eg) begin
      errors++;
      $display("FAIL %s gnt got %b%b exp %b", tag, m0_gnt, m1_gnt, eg);
    end
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {any, ew, ea, ed}) begin
      errors++;
      $display("FAIL %s mem got en=%b we=%b a=%h d=%h exp en=%b we=%b a=%h d=%h",
               tag, mem_en, mem_we, mem_addr, mem_wdata, any, ew, ea, ed);
    end
    checks++;
    if ({m0_rvalid, m1_rvalid} !== ev) begin
      errors++;
      $display("FAIL %s rvalid got %b%b exp %b", tag, m0_rvalid, m1_rvalid, ev);
    end
    if (pend) begin
      checks++;
      if ((pend_id ? m1_rdata : m0_rdata) !== pend_data) begin
        errors++;
        $display("FAIL %s rdata got %h exp %h", tag, pend_id ? m1_rdata : m0_rdata, pend_data);
      end
    end
    obs_g0 = m0_gnt;
    obs_g1 = m1_gnt;
    @(posedge clk);
    pend = 0;
    if (!any) cnt = 0;
    else begin
      if (sel == own) cnt = (cnt == 15) ? 15 : cnt + 1;
      else begin
        own = sel;
        cnt = 1;
      end
      if (ew) ref_mem[ea[7:0]] = ed;
      else begin
        pend = 1;
        pend_id = sel;
        pend_data = ref_mem[ea[7:0]];
      end
    end
    #1;
  endtask

  task automatic model_reset();
    own = 0;
    cnt = 0;
    pend = 0;
  endtask

  task automatic reset_dut();
    clrn = 1'b0;
    #2;
    clrn = 1'b1;
    model_reset();
  endtask

  task automatic idle();
    m0_req = 0;
    m1_req = 0;
  endtask

  task automatic test_reset();
    m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 0;
    m0_addr = 32'h33; m1_addr = 32'h44; m0_wdata = 32'h77;
    repeat (2) begin
      @(negedge clk);
      #1;
      checks++;
      if ({m0_gnt, m1_gnt, mem_en, mem_we, mem_addr, mem_wdata, m0_rvalid, m1_rvalid} !== '0) begin
        errors++;
        $display("FAIL reset outputs got g=%b%b en=%b we=%b a=%h d=%h rv=%b%b exp all zero",
                 m0_gnt, m1_gnt, mem_en, mem_we, mem_addr, mem_wdata, m0_rvalid, m1_rvalid);
      end
    end
    @(posedge clk);
    #1;
    clrn = 1'b1;
    model_reset();
    m0_we = 0;
    tick("reset_release");
    checks++;
    if (obs_g0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_tie got m0_gnt=%b exp 1", obs_g0);
    end
    idle();
    tick("reset_drain");
  endtask

  task automatic test_single_read();
    reset_dut();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    tick("single_read");
    idle();
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_read got rv=%b%b data=%h exp rv=10 data=deadbeef", m0_rvalid, m1_rvalid, m0_rdata);
    end
    tick("single_read_resp");
  endtask

  task automatic test_burst();
    reset_dut();
    m0_req = 1; m0_we = 0; m0_addr = 32'h1;
    m1_req = 1; m1_we = 0; m1_addr = 32'h2;
    for (int i = 0; i < 16; i++) begin
      tick("burst");
      checks++;
      if (obs_g1 !== (((i / MB) % 2) == 1)) begin
        errors++;
        $display("FAIL burst_pattern cycle %0d got m1_gnt=%b exp %b", i, obs_g1, ((i / MB) % 2) == 1);
      end
    end
    idle();
    tick("burst_drain");
  endtask

  task automatic test_alternate();
    reset_dut();
    m0_we = 0; m1_we = 0; m0_addr = 32'h4; m1_addr = 32'h8;
    for (int i = 0; i < 8; i++) begin
      m0_req = (i % 2) == 0;
      m1_req = (i % 2) == 1;
      tick("alternate");
    end
    idle();
    tick("alternate_drain");
  endtask

  task automatic test_write_read();
    reset_dut();
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h55;
    tick("wr_write");
    m1_req = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    tick("wr_read");
    idle();
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== {1'b1, 1'b0, 32'h55}) begin
      errors++;
      $display("FAIL write_read got rv=%b%b data=%h exp rv=10 data=55", m0_rvalid, m1_rvalid, m0_rdata);
    end
    tick("wr_drain");
  endtask

  task automatic test_reset_mid();
    reset_dut();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    repeat (4) tick("mid_burst");
    idle();
    checks++;
    if (m0_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre rvalid got %b exp 1", m0_rvalid);
    end
    clrn = 1'b0;
    #1;
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset rvalid got %b%b exp 00", m0_rvalid, m1_rvalid);
    end
    clrn = 1'b1;
    model_reset();
    m0_req = 1; m1_req = 1; m1_we = 0; m1_addr = 32'h5;
    tick("mid_tie");
    checks++;
    if (obs_g0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_tie got m0_gnt=%b exp 1", obs_g0);
    end
    idle();
    tick("mid_drain");
  endtask

  task automatic test_idle_burst();
    reset_dut();
    m0_req = 1; m0_we = 0; m0_addr = 32'h3;
    repeat (3) tick("ib_m0");
    idle();
    tick("ib_idle");
    m0_req = 1; m1_req = 1; m1_we = 0; m1_addr = 32'h6;
    for (int i = 0; i < 5; i++) begin
      tick("ib_both");
      checks++;
      if ({obs_g0, obs_g1} !== ((i < MB) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL idle_burst cycle %0d got %b%b exp %b", i, obs_g0, obs_g1, (i < MB) ? 2'b10 : 2'b01);
      end
    end
    idle();
    tick("ib_drain");
  endtask

  task automatic test_random();
    reset_dut();
    idle();
    obs_g0 = 0;
    obs_g1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!m0_req || obs_g0) begin
        m0_req = $urandom_range(0, 3) != 0;
        m0_we = $urandom_range(0, 2) == 0;
        m0_addr = AW'($urandom_range(0, 255));
        m0_wdata = $urandom;
      end
      if (!m1_req || obs_g1) begin
        m1_req = $urandom_range(0, 3) != 0;
        m1_we = $urandom_range(0, 2) == 0;
        m1_addr = AW'($urandom_range(0, 255));
        m1_wdata = $urandom;
      end
      tick("random");
    end
    idle();
    tick("random_drain");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_single_read();
    test_burst();
    test_alternate();
    test_write_read();
    test_reset_mid();
    test_idle_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
